keccak_round_ctrl: RTL and testbench

KECCAK_ROUND_CTRL -- requirements
Module: keccak_round_ctrl

---
 rtl/keccak_round_ctrl.sv | 107 ++++++++++
 tb/tb_keccak_round_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_round_ctrl.sv
// Round sequencer for Keccak-p[1600, n]: load pulse, n round enables ending at index 23, done pulse.
// Optional abort input enabled by defining KECCAK_CTRL_ABORT_EN.
module keccak_round_ctrl #(
    parameter int NR_FULL = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] rounds_cfg,
`ifdef KECCAK_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic       ready,
    output logic       load,
    output logic       round_en,
    output logic [4:0] round_idx,
    output logic       last_round,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

    localparam logic [4:0] NR_W     = 5'(NR_FULL);
    localparam logic [4:0] LAST_IDX = 5'(NR_FULL - 1);

    state_t     state_q, state_d;
    logic [4:0] n_q, n_d;
    logic [4:0] idx_q, idx_d;
    logic       abort_w;

`ifdef KECCAK_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= NR_W;
            idx_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        ready      = 1'b0;
        load       = 1'b0;
        round_en   = 1'b0;
        round_idx  = 5'd0;
        last_round = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = LOAD;
                    // Out-of-range requests fall back to the full permutation.
                    n_d = (rounds_cfg == 5'd0 || rounds_cfg > NR_W) ? NR_W : rounds_cfg;
                end
            end
            LOAD: begin
                busy = 1'b1;
                load = !abort_w;
                if (abort_w) begin
                    state_d = IDLE;
                end else begin
                    state_d = ROUND;
                    idx_d   = NR_W - n_q;
                end
            end
            ROUND: begin
                busy       = 1'b1;
                round_idx  = idx_q;
                // An abort suppresses this cycle's datapath update as well.
                round_en   = !abort_w;
                last_round = !abort_w && (idx_q == LAST_IDX);
                if (abort_w) begin
                    state_d = IDLE;
                    idx_d   = 5'd0;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = 5'd0;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = 5'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Self-checking bench for keccak_round_ctrl: vector table, directed corner cases, random run vs model.
module tb_keccak_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] rounds_cfg = 5'd0;
    logic       abort_r = 1'b0;
    logic       ready, load, round_en, last_round, busy, done;
    logic [4:0] round_idx;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    keccak_round_ctrl #(.NR_FULL(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rounds_cfg (rounds_cfg),
`ifdef KECCAK_CTRL_ABORT_EN
        .abort      (abort_r),
`endif
        .ready      (ready),
        .load       (load),
        .round_en   (round_en),
        .round_idx  (round_idx),
        .last_round (last_round),
        .busy       (busy),
        .done       (done)
    );

    // {ready, load, round_en, last_round, busy, done, round_idx}
    function automatic logic [10:0] pack(input logic rdy, input logic ld, input logic re,
                                         input logic lr, input logic bz, input logic dn,
                                         input logic [4:0] ix);
        return {rdy, ld, re, lr, bz, dn, ix};
    endfunction

    function automatic logic [10:0] outv();
        return {ready, load, round_en, last_round, busy, done, round_idx};
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = outv();
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got rdy/ld/re/lr/bz/dn/idx=%b required %b", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [10:0] IDLE_V = 11'b100000_00000;

    // ---------------- reference model: run described as cycles elapsed since acceptance
    int m_t = -1;
    int m_n = 24;

    function automatic int sat_n(input logic [4:0] cfg);
        return (cfg == 5'd0 || cfg > 5'd24) ? 24 : int'(cfg);
    endfunction

    function automatic logic [10:0] model_out(input logic ab);
        logic ld, re, lr, dn;
        logic [4:0] ix;
        if (m_t < 0) return IDLE_V;
        ld = (m_t == 0);
        re = (m_t >= 1 && m_t <= m_n);
        ix = re ? 5'(24 - m_n + m_t - 1) : 5'd0;
        lr = (m_t == m_n);
        dn = (m_t == m_n + 1);
        if (ab && (ld || re)) return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ix);
        return pack(1'b0, ld, re, lr, ld | re, dn, ix);
    endfunction

    task automatic model_edge(input logic s, input logic [4:0] cfg, input logic r, input logic ab);
        if (r) begin
            m_t = -1;
        end else if (m_t < 0) begin
            if (s) begin
                m_t = 0;
                m_n = sat_n(cfg);
                $display("rand txn: start cfg=%0d n=%0d at t=%0t", cfg, m_n, $time);
            end
        end else if (ab && m_t <= m_n) begin
            m_t = -1;
        end else begin
            m_t++;
            if (m_t > m_n + 1) m_t = -1;
        end
    endtask

    // ---------------- one complete run from IDLE with expected values from the vector table
    task automatic run_one(input logic [4:0] cfg, input logic [4:0] first_idx, input int lat);
        logic [10:0] exp;
        logic [4:0]  ix;
        start      = 1'b1;
        rounds_cfg = cfg;
        step();
        start = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) step();
            rounds_cfg = 5'($urandom);
            if (c == 1) begin
                exp = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
            end else if (c < lat) begin
                ix  = first_idx + 5'(c - 2);
                exp = pack(1'b0, 1'b0, 1'b1, ix == 5'd23, 1'b1, 1'b0, ix);
            end else begin
                exp = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
            end
            check($sformatf("run cfg=%0d c=%0d", cfg, c), exp);
        end
        step();
        check($sformatf("run cfg=%0d idle", cfg), IDLE_V);
        $display("txn: cfg=%0d first_idx=%0d done_at=+%0d", cfg, first_idx, lat);
    endtask

    typedef struct {
        logic [4:0] cfg;
        logic [4:0] first_idx;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{5'd24, 5'd0,  26};
        vecs[1] = '{5'd12, 5'd12, 14};
        vecs[2] = '{5'd0,  5'd0,  26};
        vecs[3] = '{5'd31, 5'd0,  26};
        vecs[4] = '{5'd1,  5'd23, 3};
        vecs[5] = '{5'd23, 5'd1,  25};
        vecs[6] = '{5'd25, 5'd0,  26};
        vecs[7] = '{5'd5,  5'd19, 7};

        #2;
        check("reset state", IDLE_V);
        step();
        rst = 1'b0;
        step();
        check("idle after reset", IDLE_V);

        for (int i = 0; i < 8; i++) begin
            run_one(vecs[i].cfg, vecs[i].first_idx, vecs[i].lat);
        end

        // start held high with n=1: load, round 23, done, ready repeating
        start      = 1'b1;
        rounds_cfg = 5'd1;
        for (int i = 0; i < 12; i++) begin
            step();
            case (i % 4)
                0: check("held load", pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0));
                1: check("held round", pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd23));
                2: check("held done", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0));
                default: check("held ready", IDLE_V);
            endcase
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("held drained", IDLE_V);
        $display("txn: start held cfg=1, 3 periods of 4 cycles");

        // reset in the middle of a 24-round run at round_idx 5
        start      = 1'b1;
        rounds_cfg = 5'd24;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("pre-reset idx5", pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5));
        rst = 1'b1;
        #1;
        check("async reset immediate", IDLE_V);
        step();
        check("reset held", IDLE_V);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            check("no done after reset", IDLE_V);
        end
        $display("txn: reset at round_idx=5, run abandoned");
        run_one(5'd24, 5'd0, 26);

`ifdef KECCAK_CTRL_ABORT_EN
        // abort at round_idx 10
        start      = 1'b1;
        rounds_cfg = 5'd24;
        step();
        start = 1'b0;
        for (int i = 0; i < 11; i++) step();
        check("pre-abort idx10", pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd10));
        abort_r = 1'b1;
        #1;
        check("abort cycle gated", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10));
        step();
        abort_r = 1'b0;
        check("abort -> idle", IDLE_V);
        for (int i = 0; i < 20; i++) begin
            step();
            check("no done after abort", IDLE_V);
        end
        $display("txn: abort at round_idx=10");

        // abort in DONE is ignored
        start      = 1'b1;
        rounds_cfg = 5'd1;
        step();
        start = 1'b0;
        step();
        step();
        abort_r = 1'b1;
        #1;
        check("abort in done", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0));
        step();
        check("after done abort", IDLE_V);

        // abort together with start in IDLE: start wins
        start = 1'b1;
        step();
        start   = 1'b0;
        abort_r = 1'b0;
        check("abort+start accepted", pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0));
        for (int i = 0; i < 4; i++) step();
        check("abort+start drained", IDLE_V);
        $display("txn: abort in DONE and abort+start in IDLE");
`endif

        // randomized traffic against the model
        m_t = -1;
        for (int i = 0; i < 600; i++) begin
            start      = ($urandom_range(0, 2) == 0);
            rounds_cfg = 5'($urandom);
            rst        = ($urandom_range(0, 59) == 0);
`ifdef KECCAK_CTRL_ABORT_EN
            abort_r    = ($urandom_range(0, 24) == 0);
`endif
            if (rst) m_t = -1;
            #1;
            check("random", model_out(abort_r));
            model_edge(start, rounds_cfg, rst, abort_r);
            step();
        end
        rst     = 1'b0;
        start   = 1'b0;
        abort_r = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
